// File: rtl/data_mem_responder_if.sv
//------------------------------------------------------------------------------
// data_mem_responder_if : request/response bus for the data memory responder
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// data_mem_responder : single-port word memory behind a valid/ready bus with
// programmable response latency. Optional macro DMEM_MISALIGN_TRAP_EN flags
// misaligned accesses instead of force-aligning them.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  data_mem_responder_if.slave  bus
);

  localparam int c_IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mem [DEPTH];

  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_commit;
  logic        w_cur_we;
  logic [1:0]  w_cur_size;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic        w_is_byte;
  logic        w_is_half;
  logic [31:0] w_eff_addr;
  logic        w_err;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic        w_unused_addr;

  assign w_accept     = (r_state == ST_IDLE) && bus.req_valid;
  assign w_enter_resp = (r_state != ST_RESP) && (w_state_nxt == ST_RESP);

  // With zero latency the access completes on the accept edge, so the
  // live request is used instead of the captured copy.
  assign w_cur_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
  assign w_cur_size  = (r_state == ST_IDLE) ? bus.req_size  : r_size;
  assign w_cur_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

  assign w_is_byte = (w_cur_size == 2'b10);
  assign w_is_half = (w_cur_size == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_err      = (w_is_half && w_cur_addr[0]) ||
                      (!w_is_byte && !w_is_half && (w_cur_addr[1:0] != 2'b00));
  assign w_eff_addr = w_cur_addr;
`else
  assign w_err      = 1'b0;
  assign w_eff_addr = {w_cur_addr[31:2],
                       w_cur_addr[1] & (w_is_byte | w_is_half),
                       w_cur_addr[0] & w_is_byte};
`endif

  assign w_idx         = w_eff_addr[c_IDX_W+1:2];
  assign w_unused_addr = &{1'b0, w_eff_addr[31:c_IDX_W+2]};

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_eff_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    w_be   = 4'b1111;
    w_wrep = w_cur_wdata;
    if (w_is_byte) begin
      w_load = {24'd0, w_shift[7:0]};
      w_be   = 4'b0001 << w_eff_addr[1:0];
      w_wrep = {4{w_cur_wdata[7:0]}};
    end else if (w_is_half) begin
      w_load = {16'd0, w_shift[15:0]};
      w_be   = w_eff_addr[1] ? 4'b1100 : 4'b0011;
      w_wrep = {2{w_cur_wdata[15:0]}};
    end
  end

  assign w_commit = w_enter_resp && w_cur_we && !w_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= 4'(LATENCY);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_cur_we || w_err) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  // Storage is deliberately left out of reset; an edge with rst high never writes.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// tb_data_mem_responder : directed scoreboard bench for data_mem_responder
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  localparam int LAT = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH   (1024),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation on every response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata %h want no response", bus.rsp_rdata);
      end else begin
        e = sb.pop_front();
        check32("rsp_rdata", bus.rsp_rdata, e.rdata);
        check32("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check32("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int hold);
    int n;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    if (hold > 0) bus.rsp_ready = 1'b0;
    issue(we, sz, a, wd);
    for (int i = 0; i < LAT; i++) begin
      check32("early_valid", {31'd0, bus.rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check32("latency_valid", {31'd0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check32("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check32("hold_rdata", bus.rsp_rdata, exp_rd);
      check32("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    n = 0;
    while (bus.rsp_valid === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check32("rsp_drain_timeout", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = SZ_W;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check32("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check32("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check32("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    do_req(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req(1'b0, SZ_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b1, SZ_W, 32'h10, 32'h11223344, 32'h0, 1'b0, 0);
    do_req(1'b1, SZ_B, 32'h13, 32'h000000AB, 32'h0, 1'b0, 0);
    do_req(1'b0, SZ_W, 32'h10, 32'h0, 32'hAB223344, 1'b0, 0);
    do_req(1'b0, SZ_B, 32'h13, 32'h0, 32'h000000AB, 1'b0, 0);
    do_req(1'b0, SZ_H, 32'h12, 32'h0, 32'h0000AB22, 1'b0, 0);
    do_req(1'b1, SZ_H, 32'h10, 32'h00005566, 32'h0, 1'b0, 0);
    do_req(1'b0, SZ_W, 32'h10, 32'h0, 32'hAB225566, 1'b0, 0);
    do_req(1'b0, SZ_B, 32'h11, 32'h0, 32'h00000055, 1'b0, 0);

    // Misaligned accesses: trapped or force-aligned depending on build
    do_req(1'b0, SZ_W, 32'h11, 32'h0, TRAP ? 32'h0 : 32'hAB225566, TRAP, 0);
    do_req(1'b1, SZ_W, 32'h11, 32'h01020304, 32'h0, TRAP, 0);
    do_req(1'b0, SZ_W, 32'h10, 32'h0, TRAP ? 32'hAB225566 : 32'h01020304, 1'b0, 0);
    do_req(1'b0, SZ_H, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h00000102, TRAP, 0);

    do_req(1'b1, SZ_W, 32'h1000, 32'h00000077, 32'h0, 1'b0, 0);
    do_req(1'b0, SZ_W, 32'h0, 32'h0, 32'h00000077, 1'b0, 5);

    do_req(1'b1, SZ_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    do_req(1'b0, SZ_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    issue(1'b1, SZ_W, 32'h20, 32'h12345678);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check32("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check32("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
    check32("abort_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check32("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    do_req(1'b0, SZ_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    do_req(1'b0, 2'b11, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    do_req(1'b1, SZ_B, 32'h22, 32'hFFFFFF5A, 32'h0, 1'b0, 0);
    do_req(1'b0, SZ_W, 32'h20, 32'h0, 32'hCA5AF00D, 1'b0, 0);

    repeat (3) @(posedge clk);
    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
